t03_fetch_unit: RTL and testbench
=================================

// Module: t03_fetch_unit
// PURPOSE
//  Instruction-fetch sequencer sitting directly downstream of the PC stage.
//  Takes the PC stage's next-fetch address, runs a single-outstanding read on
//  the instruction memory bus, latches the returned word for decode, and drives
//  the PC stage's freeze input so the PC advances exactly once per accepted
//  instruction. Also handles flush (redirect), bus timeout and retry.
// PARAMETERS
//  NOP_INSTR      32'h00000013  word presented on instr when no valid instruction (addi x0,x0,0)
//  TIMEOUT_CYCLES 16            max cycles in REQ without bus_ack before retry; must be >=2
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  pcAddr     in   32  next-fetch address from PC stage (its memory-address output)
//  stall      in   1   decode/execute cannot accept an instruction this cycle
//  flush      in   1   control redirect; discard in-flight/held instruction
//  bus_req    out  1   memory read request, held until bus_ack
//  bus_addr   out  32  read address, stable while bus_req=1
//  bus_ack    in   1   read data valid this cycle
//  bus_rdata  in   32  read data
//  instr      out  32  instruction word to decode
//  instrValid out  1   instr holds a valid fetched instruction
//  freezePc   out  1   to PC stage: 1 = hold PC, 0 = advance this cycle
//  busTimeout out  1   1-cycle pulse when a request times out (sticky count not kept)
//  misalign   out  1   misaligned-fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=ISSUE, addrReg=0, instr=NOP_INSTR, instrValid=0,
//   freezePc=1, bus_req=0, bus_addr=0, busTimeout=0, misalign=0, tmoCnt=0, discard=0.
//  FSM states: ISSUE, REQ, VALID. All outputs registered except freezePc
//   (combinational from state/stall/flush).
//  ISSUE: addrReg<=pcAddr; bus_req=0; instrValid=0; -> REQ. Always 1 cycle.
//  REQ: bus_req=1, bus_addr=addrReg; tmoCnt increments each cycle.
//   bus_ack & ~discard & ~flush: instr<=bus_rdata, instrValid<=1, -> VALID.
//   bus_ack & (discard|flush): data dropped, discard<=0, -> ISSUE.
//   flush w/o ack: discard<=1, stay REQ (request completed, never abandoned).
//   tmoCnt==TIMEOUT_CYCLES-1 w/o ack: bus_req drops, busTimeout pulses 1 cycle,
//    tmoCnt<=0, -> ISSUE (retry at current pcAddr); discard cleared.
//  VALID: instrValid=1, instr held. freezePc=0 iff ~stall & ~flush (PC advances
//   that cycle); then instrValid<=0, instr<=NOP_INSTR, -> ISSUE.
//   stall: hold everything, freezePc=1. flush (priority over stall): drop instr,
//   freezePc=1, -> ISSUE (PC stage already redirected by control).
//  freezePc=1 in ISSUE and REQ unconditionally.
//  Latency: bus_ack -> instrValid next edge; accept -> next bus_req 2 cycles later.
//  tmoCnt is $clog2(TIMEOUT_CYCLES) bits, cleared on leaving REQ.
//  bus_ack outside REQ is ignored. Reset mid-REQ: bus_req drops asynchronously.
// CONFIGURATION
//  T03_FETCH_MISALIGN_EN defined: in ISSUE, if pcAddr[1:0]!=0, no bus request;
//   -> VALID with instr=NOP_INSTR, instrValid=1, misalign=1 (held while in VALID,
//   cleared on leaving). Undefined: address passed to bus unchanged, misalign tied 0.
// TESTING
//  1 Reset, pcAddr=0, ack 2 cycles after bus_req with rdata=32'h00500093 ->
//    instr=32'h00500093, instrValid=1, freezePc=0 for exactly 1 cycle.
//  2 stall=1 for 3 cycles in VALID -> instr/instrValid held, freezePc=1 throughout,
//    no bus_req; release -> freezePc=0 one cycle, then bus_req with new pcAddr.
//  3 flush 1 cycle mid-REQ, ack arrives later with 32'hDEADBEEF -> instrValid
//    stays 0, new request issued at redirected pcAddr=32'h100.
//  4 no ack, TIMEOUT_CYCLES=16 -> bus_req high 16 cycles, busTimeout 1-cycle pulse,
//    retry request at same address.
//  5 macro on, pcAddr=32'h102 -> no bus_req, misalign=1, instr=32'h00000013;
//    macro off -> bus_addr=32'h102, misalign=0.
//  6 assert rst during REQ -> bus_req=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/t03_fetch_unit.sv
// t03_fetch_unit: instruction-fetch sequencer between the PC stage and decode.
// Runs one outstanding read on the instruction bus, latches the returned word
// for decode and holds the PC until decode accepts it. Handles flush/redirect,
// request timeout with retry, and (optionally) misaligned-fetch trapping.
//
// Optional feature: define T03_FETCH_MISALIGN_EN to turn a fetch from a
// non-word-aligned pcAddr into a NOP with misalign raised instead of a bus read.
// Without it the address goes to the bus unchanged and misalign is tied low.
module t03_fetch_unit #(
    parameter logic [31:0] NOP_INSTR      = 32'h00000013,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcAddr,
    input  logic        stall,
    input  logic        flush,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic        freezePc,
    output logic        busTimeout,
    output logic        misalign
);

    localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_REQ,
        ST_VALID
    } state_t;

    state_t            state_q;
    logic [31:0]       addr_q;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic              bus_req_q;
    logic              bus_timeout_q;
    logic              discard_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;
`ifdef T03_FETCH_MISALIGN_EN
    logic              misalign_q;
`endif

    // Timeout counter increment, kept separate so the FSM reads as transitions only.
    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
    end

    // Fetch FSM with all bus/decode outputs registered; the address register
    // doubles as bus_addr since it is only loaded in ISSUE, outside a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ISSUE;
            addr_q        <= 32'h0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_timeout_q <= 1'b0;
            discard_q     <= 1'b0;
            tmo_q         <= '0;
`ifdef T03_FETCH_MISALIGN_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            bus_timeout_q <= 1'b0;
            case (state_q)
                ST_ISSUE: begin
                    addr_q    <= pcAddr;
                    tmo_q     <= '0;
                    discard_q <= 1'b0;
`ifdef T03_FETCH_MISALIGN_EN
                    if (pcAddr[1:0] != 2'b00) begin
                        // Misaligned: present a NOP to decode, never touch the bus.
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b1;
                        misalign_q    <= 1'b1;
                        state_q       <= ST_VALID;
                    end else
`endif
                    begin
                        bus_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        tmo_q     <= '0;
                        discard_q <= 1'b0;
                        if (discard_q || flush) begin
                            // Response belongs to a redirected-away fetch.
                            state_q <= ST_ISSUE;
                        end else begin
                            instr_q       <= bus_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= ST_VALID;
                        end
                    end else if (tmo_q == TMO_MAX) begin
                        bus_req_q     <= 1'b0;
                        bus_timeout_q <= 1'b1;
                        tmo_q         <= '0;
                        discard_q     <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end else begin
                        tmo_q <= tmo_d;
                        // The bus read must still complete; just remember to drop it.
                        if (flush) begin
                            discard_q <= 1'b1;
                        end
                    end
                end

                ST_VALID: begin
                    // Leave on accept (no stall) or on flush; stall holds everything.
                    if (flush || !stall) begin
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b0;
`ifdef T03_FETCH_MISALIGN_EN
                        misalign_q    <= 1'b0;
`endif
                        state_q       <= ST_ISSUE;
                    end
                end

                default: begin
                    state_q <= ST_ISSUE;
                end
            endcase
        end
    end

    // PC advances only in the single cycle decode takes the held instruction.
    always_comb begin
        freezePc = !((state_q == ST_VALID) && !stall && !flush);
    end

    assign bus_req    = bus_req_q;
    assign bus_addr   = addr_q;
    assign instr      = instr_q;
    assign instrValid = instr_valid_q;
    assign busTimeout = bus_timeout_q;
`ifdef T03_FETCH_MISALIGN_EN
    assign misalign   = misalign_q;
`else
    assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_t03_fetch_unit.sv
// Testbench for t03_fetch_unit: directed stimulus pushes expected events
// (request issued, instruction valid, PC advance, timeout) into a queue and an
// independent monitor compares them as the DUT produces them.
module tb_t03_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam int K_TMO = 0;
    localparam int K_REQ = 1;
    localparam int K_VAL = 2;
    localparam int K_ADV = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcAddr = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] instr;
    logic        instrValid;
    logic        freezePc;
    logic        busTimeout;
    logic        misalign;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    t03_fetch_unit #(
        .NOP_INSTR(NOP),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pcAddr(pcAddr),
        .stall(stall),
        .flush(flush),
        .bus_req(bus_req),
        .bus_addr(bus_addr),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .instr(instr),
        .instrValid(instrValid),
        .freezePc(freezePc),
        .busTimeout(busTimeout),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_TMO:   return "TMO";
            K_REQ:   return "REQ";
            K_VAL:   return "VAL";
            default: return "ADV";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic seen(input int k, input logic [31:0] d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_event: got %s %h want none", kname(k), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_mis++;
                $display("FAIL event_order: got %s %h want %s %h",
                         kname(k), d, kname(e.kind), e.data);
            end
        end
    endtask

    // Waits (bounded) for bus_req to be high at a falling edge.
    task automatic wait_req(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus_req) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: bus_req low for 50 cycles, want high", tag);
        end
    endtask

    // Drives a one-cycle ack n cycles after the current request cycle.
    task automatic do_ack(input int n, input logic [31:0] data);
        repeat (n) @(posedge clk);
        #1;
        bus_ack   = 1'b1;
        bus_rdata = data;
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    // Monitor: turns DUT output activity into events and checks them in order.
    initial begin
        logic pr;
        logic pv;
        pr = 1'b0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busTimeout)          seen(K_TMO, 32'h0);
                if (bus_req && !pr)      seen(K_REQ, bus_addr);
                if (instrValid && !pv)   seen(K_VAL, instr);
                if (!freezePc)           seen(K_ADV, instr);
            end
            pr = bus_req;
            pv = instrValid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset values
        @(negedge clk);
        chk("rst_bus_req",    {31'b0, bus_req},    32'h0);
        chk("rst_bus_addr",   bus_addr,            32'h0);
        chk("rst_instr",      instr,               NOP);
        chk("rst_instrValid", {31'b0, instrValid}, 32'h0);
        chk("rst_freezePc",   {31'b0, freezePc},   32'h1);
        chk("rst_busTimeout", {31'b0, busTimeout}, 32'h0);
        chk("rst_misalign",   {31'b0, misalign},   32'h0);

        // Basic fetch from address 0, ack two cycles after request
        push(K_REQ, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_req("t1_req");
        push(K_VAL, 32'h00500093);
        push(K_ADV, 32'h00500093);
        push(K_REQ, 32'h4);
        pcAddr = 32'h4;
        do_ack(2, 32'h00500093);

        // Stall three cycles in VALID
        wait_req("t2_req");
        push(K_VAL, 32'h00a00113);
        stall = 1'b1;
        do_ack(1, 32'h00a00113);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr",      instr,               32'h00a00113);
            chk("stall_instrValid", {31'b0, instrValid}, 32'h1);
            chk("stall_freezePc",   {31'b0, freezePc},   32'h1);
            chk("stall_bus_req",    {31'b0, bus_req},    32'h0);
        end
        @(posedge clk);
        #1;
        push(K_ADV, 32'h00a00113);
        push(K_REQ, 32'h8);
        pcAddr = 32'h8;
        stall  = 1'b0;

        // Flush mid-request; late response must be dropped
        wait_req("t3_req");
        push(K_REQ, 32'h100);
        @(posedge clk);
        #1;
        flush  = 1'b1;
        pcAddr = 32'h100;
        @(posedge clk);
        #1 flush = 1'b0;
        do_ack(1, 32'hDEADBEEF);
        wait_req("t3_redirect");
        chk("t3_bus_addr", bus_addr, 32'h100);
        // Flush while the instruction is held: no PC advance
        push(K_VAL, 32'h11111111);
        push(K_REQ, 32'h200);
        do_ack(1, 32'h11111111);
        flush  = 1'b1;
        pcAddr = 32'h200;
        @(posedge clk);
        #1 flush = 1'b0;

        // Timeout: request held 16 cycles, pulse, retry at same address
        wait_req("t4_req");
        push(K_TMO, 32'h0);
        push(K_REQ, 32'h200);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_req) break;
            cnt++;
        end
        chk("t4_req_cycles", cnt, 32'd16);
        wait_req("t4_retry");
        push(K_VAL, 32'h22222222);
        push(K_ADV, 32'h22222222);
        pcAddr = 32'h102;

`ifdef T03_FETCH_MISALIGN_EN
        // Misaligned fetch becomes a NOP, no bus access
        push(K_VAL, NOP);
        push(K_ADV, NOP);
        do_ack(1, 32'h22222222);
        cnt = 0;
        for (int i = 0; i < 20 && cnt == 0; i++) begin
            @(negedge clk);
            if (misalign) cnt = 1;
        end
        chk("t5_misalign",   {31'b0, misalign},   32'h1);
        chk("t5_instr",      instr,               NOP);
        chk("t5_instrValid", {31'b0, instrValid}, 32'h1);
        chk("t5_bus_req",    {31'b0, bus_req},    32'h0);
        @(posedge clk);
        #1;
        push(K_REQ, 32'h300);
        pcAddr = 32'h300;
`else
        // Misaligned address passes to the bus unchanged
        push(K_REQ, 32'h102);
        do_ack(1, 32'h22222222);
        wait_req("t5_req");
        chk("t5_bus_addr", bus_addr,          32'h102);
        chk("t5_misalign", {31'b0, misalign}, 32'h0);
        push(K_VAL, 32'h33333333);
        push(K_ADV, 32'h33333333);
        push(K_REQ, 32'h300);
        pcAddr = 32'h300;
        do_ack(1, 32'h33333333);
`endif

        // Asynchronous reset during a request
        wait_req("t6_req");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_bus_req",    {31'b0, bus_req},    32'h0);
        chk("t6_bus_addr",   bus_addr,            32'h0);
        chk("t6_instr",      instr,               NOP);
        chk("t6_instrValid", {31'b0, instrValid}, 32'h0);
        chk("t6_freezePc",   {31'b0, freezePc},   32'h1);
        chk("t6_busTimeout", {31'b0, busTimeout}, 32'h0);
        chk("t6_misalign",   {31'b0, misalign},   32'h0);
        push(K_REQ, 32'h300);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_req("t6_after");
        push(K_VAL, 32'h44444444);
        push(K_ADV, 32'h44444444);
        push(K_REQ, 32'h304);
        pcAddr = 32'h304;
        do_ack(1, 32'h44444444);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
